// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the single write port of the 8 x BITS register file
//            between two writeback requesters (A = ALU result, B = load or
//            immediate) with round-robin fairness, and runs a clear sequence
//            that writes CLEAR_VALUE into R0..R7 on an init pulse.
// Ports    : clk, reset (async, active-high)
//            init                 - one-cycle pulse, starts the clear sequence
//            reqA/numA/dataA/ackA - requester A handshake (ack combinational)
//            reqB/numB/dataB/ackB - requester B handshake (ack combinational)
//            write/writenum/data_in - registered register-file write port
//            busy                 - registered, high while clearing
//            grantsA/grantsB      - saturating accepted-write counters, only
//                                   present when REGFILE_ARB_STATS_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int              BITS        = 16,
  parameter logic [BITS-1:0] CLEAR_VALUE = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic            reqA,
  input  logic [2:0]      numA,
  input  logic [BITS-1:0] dataA,
  output logic            ackA,
  input  logic            reqB,
  input  logic [2:0]      numB,
  input  logic [BITS-1:0] dataB,
  output logic            ackB,
  output logic            write,
  output logic [2:0]      writenum,
  output logic [BITS-1:0] data_in,
  output logic            busy
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0]     grantsA,
  output logic [15:0]     grantsB
`endif
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic c_GRANT_A = 1'b0;
  localparam logic c_GRANT_B = 1'b1;

  state_t          r_state;
  logic [2:0]      r_clear_cnt;
  logic            r_last_grant;
  logic            r_write;
  logic [2:0]      r_writenum;
  logic [BITS-1:0] r_data;
  logic            r_busy;

  logic            w_arb_open;
  logic            w_grant_a;
  logic            w_grant_b;

  // Arbitration is only open in IDLE with no init pending; init takes
  // precedence over any request in the same cycle. Gating with reset keeps
  // both acks low while reset is held.
  assign w_arb_open = !reset && (r_state == S_IDLE) && !init;

  // Under contention the requester that did not win last time goes first,
  // which also guarantees the two grants are mutually exclusive.
  assign w_grant_a = w_arb_open && reqA && (!reqB || (r_last_grant == c_GRANT_B));
  assign w_grant_b = w_arb_open && reqB && (!reqA || (r_last_grant == c_GRANT_A));

  assign ackA     = w_grant_a;
  assign ackB     = w_grant_b;
  assign write    = r_write;
  assign writenum = r_writenum;
  assign data_in  = r_data;
  assign busy     = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_clear_cnt  <= 3'd0;
      r_last_grant <= c_GRANT_B;
      r_write      <= 1'b0;
      r_writenum   <= 3'd0;
      r_data       <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (init) begin
            r_state     <= S_CLEAR;
            r_busy      <= 1'b1;
            r_clear_cnt <= 3'd0;
            r_write     <= 1'b0;
          end else if (w_grant_a) begin
            r_write      <= 1'b1;
            r_writenum   <= numA;
            r_data       <= dataA;
            r_last_grant <= c_GRANT_A;
          end else if (w_grant_b) begin
            r_write      <= 1'b1;
            r_writenum   <= numB;
            r_data       <= dataB;
            r_last_grant <= c_GRANT_B;
          end else begin
            // Address and data hold so the port only toggles on real writes.
            r_write <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_write     <= 1'b1;
          r_writenum  <= r_clear_cnt;
          r_data      <= CLEAR_VALUE;
          r_clear_cnt <= r_clear_cnt + 3'd1;
          // The count wraps to 0 here but the sequence stops, so R0 is never
          // written twice.
          if (r_clear_cnt == 3'd7) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] r_grants_a;
  logic [15:0] r_grants_b;

  // Only arbitrated writes are counted; clear-sequence writes never raise
  // an ack, so they are excluded automatically.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grants_a <= 16'd0;
      r_grants_b <= 16'd0;
    end else begin
      if (w_grant_a && (r_grants_a != 16'hFFFF)) begin
        r_grants_a <= r_grants_a + 16'd1;
      end
      if (w_grant_b && (r_grants_b != 16'hFFFF)) begin
        r_grants_b <= r_grants_b + 16'd1;
      end
    end
  end

  assign grantsA = r_grants_a;
  assign grantsB = r_grants_b;
`endif

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8x16 register file between two writeback requesters, A (ALU result path) and B (load/immediate path).
- Also runs an init sequence that clears R0..R7 on command.
- Sits between the datapath writeback sources and the register file's write/writenum/data_in inputs.
- Registered outputs: one write per clock at most, with round-robin fairness under contention.

Parameters:
- bits, 16, data width of the write port and the requester data buses.
- CLEAR_VALUE, 16'h0000, value written to every register during the init sequence.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  single-cycle pulse that starts the clear sequence.
- reqA  input  1  requester A has a pending write.
- numA  input  3  destination register number for A.
- dataA  input  bits  write data for A.
- ackA  output  1  A's write accepted this cycle (combinational).
- reqB  input  1  requester B has a pending write.
- numB  input  3  destination register number for B.
- dataB  input  bits  write data for B.
- ackB  output  1  B's write accepted this cycle (combinational).
- write  output  1  register-file write enable (registered).
- writenum  output  3  register-file write address (registered).
- data_in  output  bits  register-file write data (registered).
- busy  output  1  high while the clear sequence runs (registered).

Behaviour:
- Reset (async, immediate) sets:
  - write=0, writenum=0, data_in=0, busy=0
  - state=IDLE, clear counter=0
  - last_grant=B, so A wins the first contention.
  - ackA and ackB are 0 while reset is high.
- States: IDLE, CLEAR.
- IDLE arbitration (combinational, same cycle as the request):
  - Only reqA high: ackA=1.
  - Only reqB high: ackB=1.
  - Both high: grant the requester not equal to last_grant.
  - Neither high: no ack.
  - At most one ack is high per cycle.
- IDLE on posedge with a grant:
  - write<=1, writenum<=num of the winner, data_in<=data of the winner.
  - last_grant<=winner.
- IDLE on posedge with no grant: write<=0; writenum and data_in hold their values.
- Latency: a write acked in cycle k appears on the port in cycle k+1. The register file loads it at the end of cycle k+1, and the new value is readable in cycle k+2.
- Handshake:
  - A requester holds req, num and data stable until it sees its ack high at a posedge.
  - A requester may drop req in the cycle after its ack, or keep req high to issue back-to-back writes.
  - An un-acked request is never lost; it waits.
- init in IDLE:
  - Enter CLEAR on the next posedge, with busy<=1 and counter<=0.
  - If init and a request arrive in the same cycle, init wins: no ack is given that cycle.
- CLEAR:
  - Each cycle: write<=1, writenum<=counter, data_in<=CLEAR_VALUE, counter<=counter+1.
  - ackA=ackB=0 throughout.
  - After writenum=7 is issued, return to IDLE with busy<=0. write returns to 0 on the following cycle unless a grant occurs.
  - busy is high for exactly 8 cycles. init pulses during CLEAR are ignored (no restart).
- Wrap-around: the 3-bit counter wraps 7->0, but the sequence ends at 7, so the wrap is never issued.
- Two writes to the same register in consecutive cycles: both are issued in order, and the later value wins.
- last_grant is unchanged by CLEAR.
- Reset mid-CLEAR: the sequence aborts immediately and write drops to 0; remaining registers keep their old contents.

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN.
- When defined, adds two outputs, grantsA[15:0] and grantsB[15:0]:
  - Each counts accepted writes for its requester.
  - Each saturates at 16'hFFFF.
  - Both reset to 0.
  - Clear-sequence writes are not counted.
- When undefined, the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset then reqA=1, numA=3, dataA=16'h00AB for one cycle -> ackA=1 that cycle; next cycle write=1, writenum=3, data_in=16'h00AB; following cycle write=0.
- reqA and reqB held high for 4 cycles (numA=1/dataA=16'h1111, numB=2/dataB=16'h2222) -> acks alternate A,B,A,B; writenum sequence 1,2,1,2; never both acks high.
- init pulse with registers preloaded to 16'hFFFF -> busy high for 8 cycles, writenum 0..7 with data_in=16'h0000, then reads of R0..R7 all return 16'h0000.
- init pulse with reqB=1 in the same cycle and held -> no ackB during 8 CLEAR cycles; ackB asserted in the first IDLE cycle; B's write issued after writenum=7.
- Reset asserted during CLEAR at writenum=4 -> write=0 and busy=0 immediately, without waiting for clk; R5..R7 keep prior values.
- With REGFILE_ARB_STATS_EN: 5 A grants, 3 B grants, one init -> grantsA=5, grantsB=3.
